// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ byte sources.
// Sequences the level tx_start/tx_busy handshake for one frame per grant, then acks or flags err.
module uart_tx_sched #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int START_TO = 16,
  parameter int GAP      = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    grant,
  output logic               err,
  output logic               tx_start,
  output logic [DW-1:0]      tx_data,
  input  logic               tx_busy,
  output logic               sched_busy,
  output logic [1:0]         dbg_state_o
);

  localparam int PW = $clog2(NREQ);
  localparam int TW = $clog2(START_TO + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, START, SEND, RELEASE} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic              tx_start_q, tx_start_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic              sched_busy_q, sched_busy_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;

  logic              win_found;
  logic [PW-1:0]     win_idx;
  logic [PW-1:0]     cand;

  // Scan upward from the index after the last one served, so it gets lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_d      = '0;
    err_d      = 1'b0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    ptr_d      = ptr_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = START;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          tx_data_d        = data[int'(win_idx)*DW +: DW];
          ptr_d            = win_idx;
          tx_start_d       = 1'b1;
          to_cnt_d         = '0;
        end
      end
      START: begin
        if (tx_busy) begin
          state_d = SEND;
        end else if (to_cnt_q == TW'(START_TO - 1)) begin
          // Pointer keeps the failed index so a dead requester cannot monopolise the link.
          state_d    = RELEASE;
          err_d      = 1'b1;
          grant_d    = '0;
          tx_start_d = 1'b0;
          gap_cnt_d  = '0;
        end else if (to_cnt_q != {TW{1'b1}}) begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      SEND: begin
        if (!tx_busy) begin
          state_d    = RELEASE;
          ack_d      = grant_q;
          grant_d    = '0;
          tx_start_d = 1'b0;
          gap_cnt_d  = '0;
        end
      end
      RELEASE: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    sched_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      sched_busy_q <= 1'b0;
      ptr_q        <= PW'(NREQ - 1);
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      sched_busy_q <= sched_busy_d;
      ptr_q        <= ptr_d;
      to_cnt_q     <= to_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign ack         = ack_q;
  assign grant       = grant_q;
  assign err         = err_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign sched_busy  = sched_busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit path (TX FSM plus shift register) between NREQ byte sources. It grants one requester at a time and latches that requester's byte onto the transmitter data input. It sequences the transmitter's level-sensitive tx_start/tx_busy handshake for exactly one frame, then acknowledges the requester. It sits between the host-side byte producers and uart_tx.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 8: data byte width
- START_TO, 16: cycles allowed for tx_busy to rise after tx_start asserts, >=2
- GAP, 1: cycles tx_start is held low between frames, >=1
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- req  in  NREQ  per-requester request level; requester holds it until its ack
- data  in  NREQ*DW  requester i byte at bits [i*DW +: DW]
- ack  out  NREQ  one-hot, one-cycle pulse: frame for requester i has completed
- grant  out  NREQ  one-hot owner of the transmitter; 0 when idle
- err  out  1  one-cycle pulse: start timeout, frame not sent
- tx_start  out  1  level to transmitter; must stay high for the whole frame
- tx_data  out  DW  byte presented to transmitter, stable while grant is non-zero
- tx_busy  in  1  transmitter busy level
- sched_busy  out  1  high in any state other than IDLE

## Operation
- All outputs are registered. Reset values: state IDLE, grant=0, ack=0, err=0, tx_start=0, tx_data=0, sched_busy=0, rr pointer=NREQ-1, so req[0] has first priority.
- States:
  - IDLE
  - START: tx_start=1, wait for tx_busy=1.
  - SEND: tx_start=1, wait for tx_busy=0.
  - RELEASE: tx_start=0 for GAP cycles.
- Transitions:
  - IDLE with any req bit set -> START. The winner is the first set bit scanning upward from pointer+1, modulo NREQ. grant, tx_data and the pointer are loaded with the winner's index and byte on this edge.
  - START with tx_busy=1 -> SEND. If START_TO cycles elapse in START with tx_busy still 0, go to RELEASE and pulse err. No ack is issued, and the pointer keeps the failed index so the requester does not starve the others.
  - SEND with tx_busy=0 -> RELEASE, pulse ack[granted] on that edge, clear grant.
  - RELEASE after GAP cycles -> IDLE. The low gap lets the transmitter's stop state fall back to its idle state.
- tx_data is captured once, at grant. Changes on data[] afterwards have no effect on the frame in flight.
- If a requester drops req after grant, the frame still completes and ack is still pulsed. Requests are never cancelled mid-frame.
- tx_busy rising while in IDLE or RELEASE is ignored. No state change occurs.
- The timeout counter is clog2(START_TO+1) bits wide, cleared on entry to START, and saturates; it does not wrap.
- RELEASE counter is clog2(GAP+1) bits, cleared on entry.
- Reset asserted mid-frame forces every output to its reset value immediately (asynchronously). The transmitter sees tx_start=0 and aborts the frame.

## Timing
- Grant latency: req rises at edge n while IDLE -> grant, tx_data and tx_start are high after edge n+1.
- The transmitter's busy level rises one cycle after tx_start. START is therefore normally 1-2 cycles.
- ack is high for the single cycle after the edge at which tx_busy=0 is sampled in SEND. grant falls in that same cycle.
- Back-to-back cost is GAP+1 cycles of overhead between frames: tx_start is low for GAP cycles in RELEASE, and IDLE takes one cycle to grant again.
- Simultaneous requests are resolved purely by the rr pointer. The previously served index has lowest priority.
- ack and err are never asserted together. Exactly one of them occurs per grant.

## Test plan
- Single request: req=4'b0100, data[2]=8'hA5, model transmitter busy for 11 cycles -> grant=4'b0100 and tx_data=8'hA5 one cycle later; ack=4'b0100 for one cycle after busy falls; tx_start low for GAP cycles.
- Round robin: req=4'b1111 held, each requester re-raises its request after its ack -> grant order 0,1,2,3,0. Exactly one ack per frame, each to the matching requester.
- Start timeout: tx_busy tied 0, req[1]=1, START_TO=16 -> err pulses 16 cycles after tx_start rises, no ack, tx_start low; with req[1] and req[2] both high, the next grant is 4'b0100.
- Request withdrawal: req[3] drops two cycles into SEND, and data[3] changes to 8'h00 -> tx_data holds the granted byte; ack[3] still pulses.
- Reset mid-frame: assert rstn=0 during SEND -> tx_start, grant and sched_busy go 0 without waiting for a clock edge. After release, pending req[0] is granted first.
- Spurious busy: tx_busy pulsed while in IDLE with req=0 -> no state change, all outputs remain 0.
